// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the single-port data memory.
// Optional build macro DMEM_ARB_RANGE_CHECK_EN adds out-of-range address blocking and an err output.
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int n = 16,
    parameter int r = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req,
    input  logic [1:0]   we,
    input  logic [n-1:0] addr0,
    input  logic [n-1:0] addr1,
    input  logic [n-1:0] wdata0,
    input  logic [n-1:0] wdata1,
    output logic [1:0]   ack,
    output logic [n-1:0] rdata,
    output logic         busy,
    output logic         owner,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    output logic         mem_we,
    input  logic [n-1:0] mem_rdata
`ifdef DMEM_ARB_RANGE_CHECK_EN
    ,
    output logic [1:0]   err
`endif
);

`ifdef DMEM_ARB_RANGE_CHECK_EN
    localparam bit RangeChkEn = 1'b1;
`else
    localparam bit RangeChkEn = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t       state_q;
    logic         ptr_q;
    logic         owner_q;
    logic         we_q;
    logic         oor_q;
    logic         mem_we_q;
    logic [1:0]   ack_q;
    logic [n-1:0] rdata_q;
    logic [n-1:0] mem_addr_q;
    logic [n-1:0] mem_wdata_q;
`ifdef DMEM_ARB_RANGE_CHECK_EN
    logic [1:0]   err_q;
`endif

    logic         owner_d;
    logic         we_d;
    logic         oor_d;
    logic [n-1:0] addr_d;
    logic [n-1:0] wdata_d;

    // Contention goes to the pointer; a lone request wins outright.
    always_comb begin
        owner_d = (req[0] & req[1]) ? ptr_q : req[1];
        addr_d  = owner_d ? addr1  : addr0;
        wdata_d = owner_d ? wdata1 : wdata0;
        we_d    = we[owner_d];
        oor_d   = RangeChkEn ? (|addr_d[n-1:r]) : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            ack_q       <= 2'b00;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef DMEM_ARB_RANGE_CHECK_EN
            err_q       <= 2'b00;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        owner_q     <= owner_d;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= wdata_d;
                        we_q        <= we_d;
                        oor_q       <= oor_d;
                        mem_we_q    <= we_d & ~oor_d;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we_q <= 1'b0;
                    rdata_q  <= (we_q | oor_q) ? '0 : mem_rdata;
                    ack_q    <= owner_q ? 2'b10 : 2'b01;
`ifdef DMEM_ARB_RANGE_CHECK_EN
                    err_q    <= oor_q ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
`endif
                    state_q  <= RESP;
                end
                RESP: begin
                    ack_q   <= 2'b00;
`ifdef DMEM_ARB_RANGE_CHECK_EN
                    err_q   <= 2'b00;
`endif
                    ptr_q   <= ~owner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
`ifdef DMEM_ARB_RANGE_CHECK_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural data memory, reference memory and an ack/rdata scoreboard.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int N = 16;
    localparam int R = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req, we;
    logic [N-1:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]   ack;
    logic [N-1:0] rdata;
    logic         busy, owner;
    logic [N-1:0] mem_addr, mem_wdata;
    logic         mem_we;
    logic [N-1:0] mem_rdata;
`ifdef DMEM_ARB_RANGE_CHECK_EN
    logic [1:0]   err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]   ack;
        logic [N-1:0] rdata;
        logic [1:0]   err;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    logic [N-1:0] mem[64];
    logic [N-1:0] ref_mem[64];
    logic         init_done = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.n(N), .r(R)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack), .rdata(rdata), .busy(busy), .owner(owner),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_RANGE_CHECK_EN
        , .err(err)
`endif
    );

    function automatic logic [N-1:0] init_val(input int i);
        return (i == 7) ? '0 : N'(i * 273);
    endfunction

    // Single-port memory: combinational read, write on posedge, low R bits index.
    assign mem_rdata = mem[mem_addr[R-1:0]];
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
            init_done <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr[R-1:0]] <= mem_wdata;
        end
    end

    // Every ack pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ack !== 2'b00) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack: ack=%b rdata=%h, required no ack", ack, rdata);
            end else begin
                mon_e = sb.pop_front();
                if (ack !== mon_e.ack || rdata !== mon_e.rdata) begin
                    n_fail++;
                    $display("FAIL scoreboard_resp: ack=%b rdata=%h, required ack=%b rdata=%h",
                             ack, rdata, mon_e.ack, mon_e.rdata);
                end
`ifdef DMEM_ARB_RANGE_CHECK_EN
                n_checks++;
                if (err !== mon_e.err) begin
                    n_fail++;
                    $display("FAIL scoreboard_err: err=%b, required %b", err, mon_e.err);
                end
`endif
            end
        end
    end

    task automatic push_exp(input int i, input logic w, input logic [N-1:0] a, input logic [N-1:0] d);
        exp_t e;
        logic oor;
        oor = 1'b0;
`ifdef DMEM_ARB_RANGE_CHECK_EN
        oor = |a[N-1:R];
`endif
        e.ack   = (i != 0) ? 2'b10 : 2'b01;
        e.rdata = (w || oor) ? '0 : ref_mem[a[R-1:0]];
        e.err   = oor ? e.ack : 2'b00;
        if (w && !oor) ref_mem[a[R-1:0]] = d;
        sb.push_back(e);
    endtask

    task automatic drive(input int i, input logic w, input logic [N-1:0] a, input logic [N-1:0] d);
        req = 2'b00;
        req[i] = 1'b1;
        we[i] = w;
        if (i == 0) begin addr0 = a; wdata0 = d; end
        else        begin addr1 = a; wdata1 = d; end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after RESP.
    task automatic issue(input int i, input logic w, input logic [N-1:0] a, input logic [N-1:0] d);
        drive(i, w, a, d);
        push_exp(i, w, a, d);
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(negedge clk);
        n_checks += 7;
        if (ack !== 2'b00)   begin n_fail++; $display("FAIL reset_ack: got %b, required 00", ack); end
        if (rdata !== '0)    begin n_fail++; $display("FAIL reset_rdata: got %h, required 0000", rdata); end
        if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (owner !== 1'b0)  begin n_fail++; $display("FAIL reset_owner: got %b, required 0", owner); end
        if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h, required 0000", mem_addr); end
        if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h, required 0000", mem_wdata); end
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b, required 0", mem_we); end
`ifdef DMEM_ARB_RANGE_CHECK_EN
        n_checks++;
        if (err !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b, required 00", err); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, required 0", busy); end
    endtask

    task automatic test_store;
        drive(0, 1'b1, N'(5), 16'h1234);
        push_exp(0, 1'b1, N'(5), 16'h1234);
        @(negedge clk);
        req = 2'b00;
        n_checks += 5;
        if (mem_we !== 1'b1)        begin n_fail++; $display("FAIL store_access_we: got %b, required 1", mem_we); end
        if (mem_addr !== N'(5))     begin n_fail++; $display("FAIL store_access_addr: got %h, required 0005", mem_addr); end
        if (mem_wdata !== 16'h1234) begin n_fail++; $display("FAIL store_access_wdata: got %h, required 1234", mem_wdata); end
        if (busy !== 1'b1)          begin n_fail++; $display("FAIL store_access_busy: got %b, required 1", busy); end
        if (owner !== 1'b0)         begin n_fail++; $display("FAIL store_access_owner: got %b, required 0", owner); end
        @(negedge clk);
        n_checks += 3;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL store_resp_we: got %b, required 0", mem_we); end
        if (busy !== 1'b1)   begin n_fail++; $display("FAIL store_resp_busy: got %b, required 1", busy); end
        if (ack !== 2'b01)   begin n_fail++; $display("FAIL store_resp_ack: got %b, required 01", ack); end
        @(negedge clk);
        n_checks += 3;
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL store_idle_busy: got %b, required 0", busy); end
        if (ack !== 2'b00)       begin n_fail++; $display("FAIL store_idle_ack: got %b, required 00", ack); end
        if (mem[5] !== 16'h1234) begin n_fail++; $display("FAIL store_mem5: got %h, required 1234", mem[5]); end
    endtask

    task automatic test_load;
        issue(0, 1'b0, N'(5), '0);
        n_checks++;
        if (rdata !== 16'h1234) begin n_fail++; $display("FAIL load_rdata_hold: got %h, required 1234", rdata); end
    endtask

    task automatic test_contention;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(0, 1'b0, N'(1), '0);
        push_exp(1, 1'b0, N'(2), '0);
        push_exp(0, 1'b0, N'(1), '0);
        push_exp(1, 1'b0, N'(2), '0);
        req = 2'b11; we = 2'b00; addr0 = N'(1); addr1 = N'(2);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k % 3 == 0) begin
                n_checks++;
                if (owner !== 1'((k / 3) % 2))
                    begin n_fail++; $display("FAIL rr_owner_%0d: got %b, required %0d", k / 3, owner, (k / 3) % 2); end
            end
            n_checks++;
            if (k % 3 == 1) begin
                if (ack !== (((k / 3) % 2 == 1) ? 2'b10 : 2'b01))
                    begin n_fail++; $display("FAIL rr_ack_%0d: got %b at cycle %0d", k / 3, ack, k); end
            end else if (ack !== 2'b00) begin
                n_fail++; $display("FAIL rr_ack_gap: got %b at cycle %0d, required 00", ack, k);
            end
        end
        req = 2'b00;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_end_busy: got %b, required 0", busy); end
    endtask

    task automatic test_req1_store;
        issue(1, 1'b1, N'(63), 16'hBEEF);
        issue(0, 1'b0, N'(63), '0);
        n_checks++;
        if (rdata !== 16'hBEEF) begin n_fail++; $display("FAIL req1_readback: got %h, required beef", rdata); end
    endtask

    task automatic test_reset_mid_access;
        drive(0, 1'b1, N'(7), 16'hDEAD);
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_we: got %b, required 1", mem_we); end
        #1 rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we: got %b, required 0", mem_we); end
        if (busy !== 1'b0)   begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        if (ack !== 2'b00)   begin n_fail++; $display("FAIL midrst_ack: got %b, required 00", ack); end
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        issue(0, 1'b0, N'(7), '0);
        n_checks += 2;
        if (rdata !== 16'h0000) begin n_fail++; $display("FAIL midrst_readback: got %h, required 0000", rdata); end
        if (mem[7] !== 16'h0000) begin n_fail++; $display("FAIL midrst_mem7: got %h, required 0000", mem[7]); end
    endtask

    task automatic test_addr_range;
`ifdef DMEM_ARB_RANGE_CHECK_EN
        logic [N-1:0] old0;
        old0 = ref_mem[0];
        drive(0, 1'b1, 16'h0040, 16'h5555);
        push_exp(0, 1'b1, 16'h0040, 16'h5555);
        @(negedge clk);
        req = 2'b00;
        n_checks++;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL oor_we: got %b, required 0", mem_we); end
        @(negedge clk);
        n_checks++;
        if (err !== 2'b01) begin n_fail++; $display("FAIL oor_err: got %b, required 01", err); end
        @(negedge clk);
        issue(0, 1'b0, N'(0), '0);
        n_checks += 2;
        if (rdata !== old0)  begin n_fail++; $display("FAIL oor_addr0_read: got %h, required %h", rdata, old0); end
        if (mem[0] !== old0) begin n_fail++; $display("FAIL oor_addr0_mem: got %h, required %h", mem[0], old0); end
`else
        issue(0, 1'b1, 16'h0048, 16'h7777);
        issue(0, 1'b0, N'(8), '0);
        n_checks++;
        if (rdata !== 16'h7777) begin n_fail++; $display("FAIL wrap_readback: got %h, required 7777", rdata); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        test_reset;
        test_store;
        test_load;
        test_contention;
        test_req1_store;
        test_reset_mid_access;
        test_addr_range;
        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL missing_acks: %0d outstanding, required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
